// File: rtl/digit_scan_mux.sv
// digit_scan_mux: scans four 5-bit character codes onto one shared 7-segment decoder,
// with per-slot dead time, per-digit blanking and a frame tick. Define DIGIT_BLINK_EN for digit blinking.
module digit_scan_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] dig0,
  input  logic [4:0] dig1,
  input  logic [4:0] dig2,
  input  logic [4:0] dig3,
  input  logic [3:0] blank_mask,
`ifdef DIGIT_BLINK_EN
  input  logic [3:0] blink_mask,
`endif
  output logic [4:0] code,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int            CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD   = CW'(DEAD_CYCLES);
  localparam logic [4:0]    CODE_SPACE = 5'b10110;

  typedef enum logic {PH_DARK, PH_LIT} phase_t;

  generate
    if (REFRESH_DIV < 2 || DEAD_CYCLES < 0 || DEAD_CYCLES >= REFRESH_DIV || BLINK_FRAMES < 1) begin : g_bad_params
      $error("digit_scan_mux: illegal REFRESH_DIV/DEAD_CYCLES/BLINK_FRAMES combination");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          slot_end;
  logic          frame_end;
  logic          blink_dark;
  phase_t        phase;
  logic [4:0]    dig_sel;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

`ifdef DIGIT_BLINK_EN
  localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Phase flips on the same edge that starts the next frame, so blinking covers whole slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_dark = blink_phase & blink_mask[idx];
`else
  assign blink_dark = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    phase   = PH_LIT;
    dig_sel = dig0;
    if ((cnt < CNT_DEAD) || blank_mask[idx] || blink_dark)
      phase = PH_DARK;
    case (idx)
      2'd0:    dig_sel = dig0;
      2'd1:    dig_sel = dig1;
      2'd2:    dig_sel = dig2;
      default: dig_sel = dig3;
    endcase
  end

  // Outputs are registered so the decoder and anodes see exactly one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= 4'b1111;
      code       <= CODE_SPACE;
      digit_idx  <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      digit_idx  <= idx;
      frame_tick <= frame_end;
      if (phase == PH_LIT) begin
        an   <= ~(4'b0001 << idx);
        code <= dig_sel;
      end else begin
        an   <= 4'b1111;
        code <= CODE_SPACE;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux: two instances (dead time 2 and 0) against a
// time-based reference model; blink scenario only when DIGIT_BLINK_EN is defined.
module tb_digit_scan_mux;

  localparam int         RD    = 8;
  localparam int         DEAD  = 2;
  localparam int         BF    = 2;
  localparam logic [4:0] SPACE = 5'b10110;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] dig0 = 5'd0, dig1 = 5'd0, dig2 = 5'd0, dig3 = 5'd0;
  logic [3:0] blank_mask = 4'd0;
  logic [3:0] blink_mask = 4'd0;

  logic [4:0] code, code_z;
  logic [3:0] an, an_z;
  logic [1:0] digit_idx, idx_z;
  logic       frame_tick, tick_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_scan_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .blank_mask(blank_mask),
`ifdef DIGIT_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .code(code), .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  digit_scan_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(0), .BLINK_FRAMES(BF)) dut_z (
    .clk(clk), .reset(reset),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .blank_mask(blank_mask),
`ifdef DIGIT_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .code(code_z), .an(an_z), .digit_idx(idx_z), .frame_tick(tick_z)
  );

  logic [11:0] obs_a, obs_z;
  assign obs_a = {frame_tick, digit_idx, an, code};
  assign obs_z = {tick_z, idx_z, an_z, code_z};

  // Reference: the scan position is just the number of clocks since reset; slot, digit and
  // frame fall out of division. Result packs {tick, idx, an, code}.
  function automatic logic [11:0] ref_out(int p, int dead, logic [4:0] d0, logic [4:0] d1,
                                          logic [4:0] d2, logic [4:0] d3,
                                          logic [3:0] blank, logic [3:0] blink);
    logic [4:0] chars [4];
    int         c, d, frame;
    logic       dark;
    logic [3:0] an_v;
    chars[0] = d0; chars[1] = d1; chars[2] = d2; chars[3] = d3;
    c     = p % RD;
    d     = (p / RD) % 4;
    frame = p / (4 * RD);
    dark  = (c < dead) || blank[d] || ((((frame / BF) % 2) == 1) && blink[d]);
    an_v  = 4'b1111;
    if (!dark) an_v[d] = 1'b0;
    return {(d == 3 && c == RD - 1), 2'(d), an_v, dark ? SPACE : chars[d]};
  endfunction

  int          pos;
  logic [11:0] exp_a, exp_z;
  logic [3:0]  model_blink;

`ifdef DIGIT_BLINK_EN
  assign model_blink = blink_mask;
`else
  assign model_blink = 4'b0000;
`endif

  always @(posedge clk) begin
    if (reset) begin
      pos   <= 0;
      exp_a <= {1'b0, 2'd0, 4'b1111, SPACE};
      exp_z <= {1'b0, 2'd0, 4'b1111, SPACE};
    end else begin
      exp_a <= ref_out(pos, DEAD, dig0, dig1, dig2, dig3, blank_mask, model_blink);
      exp_z <= ref_out(pos, 0, dig0, dig1, dig2, dig3, blank_mask, model_blink);
      pos   <= pos + 1;
    end
  end

  // Holds reset for n edges; returns at the negedge that begins output cycle 0.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic lit;
    dig0 = 5'h01; dig1 = 5'h02; dig2 = 5'h03; dig3 = 5'h04;
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    do_reset(3);
    checks++;
    if (digit_idx !== 2'd0 || frame_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idx_tick: got idx=%0d tick=%b expected idx=0 tick=0", digit_idx, frame_tick);
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      lit = (k >= 3) && (k <= 8);
      checks++;
      if (an !== (lit ? 4'b1110 : 4'b1111)) begin
        errors++;
        $display("[TB] FAIL reset_an cycle %0d: got %b expected %b", k, an, lit ? 4'b1110 : 4'b1111);
      end
      checks++;
      if (code !== (lit ? 5'b00001 : SPACE)) begin
        errors++;
        $display("[TB] FAIL reset_code cycle %0d: got %b expected %b", k, code, lit ? 5'b00001 : SPACE);
      end
      checks++;
      if (obs_z !== exp_z) begin
        errors++;
        $display("[TB] FAIL reset_model_z cycle %0d: got %h expected %h", k, obs_z, exp_z);
      end
    end
  endtask

  task automatic test_full_scan;
    int lit_cnt [4];
    int ticks, last_tick;
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    ticks = 0; last_tick = -1;
    dig0 = 5'h01; dig1 = 5'h02; dig2 = 5'h03; dig3 = 5'h04;
    do_reset(2);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("[TB] FAIL scan_model cycle %0d: got %h expected %h", k, obs_a, exp_a);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("[TB] FAIL scan_onehot cycle %0d: got %b expected at most one low bit", k, an);
      end
      for (int d = 0; d < 4; d++) begin
        logic [3:0] pat;
        pat = 4'b1111;
        pat[d] = 1'b0;
        if (an === pat) lit_cnt[d]++;
      end
      if (frame_tick === 1'b1) begin
        ticks++;
        last_tick = k;
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (lit_cnt[d] != 12) begin
        errors++;
        $display("[TB] FAIL scan_lit_count digit %0d: got %0d expected 12", d, lit_cnt[d]);
      end
    end
    checks++;
    if (ticks != 2 || last_tick != 64) begin
      errors++;
      $display("[TB] FAIL scan_frame_tick: got %0d ticks last at %0d expected 2 ticks last at 64", ticks, last_tick);
    end
  endtask

  task automatic test_blanking;
    blank_mask = 4'b0100;
    do_reset(1);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      checks++;
      if (an === 4'b1011) begin
        errors++;
        $display("[TB] FAIL blank_digit2 cycle %0d: got %b expected not 1011", k, an);
      end
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("[TB] FAIL blank_model cycle %0d: got %h expected %h", k, obs_a, exp_a);
      end
    end
    blank_mask = 4'b0000;
    do_reset(1);
    repeat (4) @(negedge clk);
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL blank_pre_lit: got %b expected 1110", an);
    end
    blank_mask = 4'b0001;
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || code !== SPACE) begin
      errors++;
      $display("[TB] FAIL blank_midslot: got an=%b code=%b expected an=1111 code=%b", an, code, SPACE);
    end
    blank_mask = 4'b0000;
  endtask

  task automatic test_random;
    logic [3:0] prev_an;
    do_reset(1);
    prev_an = 4'b1111;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("[TB] FAIL rand_model cycle %0d: got %h expected %h", k, obs_a, exp_a);
      end
      checks++;
      if (obs_z !== exp_z) begin
        errors++;
        $display("[TB] FAIL rand_model_z cycle %0d: got %h expected %h", k, obs_z, exp_z);
      end
      checks++;
      if (prev_an !== 4'b1111 && an !== 4'b1111 && an !== prev_an) begin
        errors++;
        $display("[TB] FAIL rand_dead_gap cycle %0d: got %b after %b expected an all-high cycle between", k, an, prev_an);
      end
      checks++;
      if ($countones(~an_z) > 1) begin
        errors++;
        $display("[TB] FAIL rand_onehot_z cycle %0d: got %b expected at most one low bit", k, an_z);
      end
      prev_an = an;
      dig0 = 5'($urandom);
      dig1 = 5'($urandom);
      dig2 = 5'($urandom);
      dig3 = 5'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
    end
    blank_mask = 4'b0000;
  endtask

  task automatic test_mid_reset;
    dig0 = 5'h0a; dig1 = 5'h0b; dig2 = 5'h0c; dig3 = 5'h0d;
    do_reset(1);
    repeat (21) @(negedge clk);
    checks++;
    if (digit_idx !== 2'd2) begin
      errors++;
      $display("[TB] FAIL midreset_pre_idx: got %0d expected 2", digit_idx);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || digit_idx !== 2'd0 || code !== SPACE || frame_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got an=%b idx=%0d code=%b tick=%b expected 1111/0/%b/0",
               an, digit_idx, code, frame_tick, SPACE);
    end
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("[TB] FAIL midreset_model cycle %0d: got %h expected %h", k, obs_a, exp_a);
      end
      if (k == 3) begin
        checks++;
        if (an !== 4'b1110 || code !== 5'h0a) begin
          errors++;
          $display("[TB] FAIL midreset_restart: got an=%b code=%h expected an=1110 code=0a", an, code);
        end
      end
    end
  endtask

  task automatic test_dead_zero;
    dig0 = 5'h05; dig1 = 5'h06; dig2 = 5'h07; dig3 = 5'h08;
    do_reset(1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (obs_z !== exp_z) begin
        errors++;
        $display("[TB] FAIL dead0_model cycle %0d: got %h expected %h", k, obs_z, exp_z);
      end
      if (k == 1 || k == 8) begin
        checks++;
        if (an_z !== 4'b1110 || code_z !== 5'h05) begin
          errors++;
          $display("[TB] FAIL dead0_digit0 cycle %0d: got an=%b code=%h expected an=1110 code=05", k, an_z, code_z);
        end
      end
      if (k == 9) begin
        checks++;
        if (an_z !== 4'b1101 || code_z !== 5'h06) begin
          errors++;
          $display("[TB] FAIL dead0_switch: got an=%b code=%h expected an=1101 code=06", an_z, code_z);
        end
      end
    end
  endtask

`ifdef DIGIT_BLINK_EN
  task automatic test_blink;
    int lit0 [6];
    int lit1 [6];
    for (int f = 0; f < 6; f++) begin
      lit0[f] = 0;
      lit1[f] = 0;
    end
    dig0 = 5'h01; dig1 = 5'h02; dig2 = 5'h03; dig3 = 5'h04;
    blink_mask = 4'b0001;
    do_reset(1);
    for (int k = 1; k <= 6 * 4 * RD; k++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) begin
        errors++;
        $display("[TB] FAIL blink_model cycle %0d: got %h expected %h", k, obs_a, exp_a);
      end
      if (an === 4'b1110) lit0[(k - 1) / (4 * RD)]++;
      if (an === 4'b1101) lit1[(k - 1) / (4 * RD)]++;
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (lit0[f] != ((f == 2 || f == 3) ? 0 : RD - DEAD)) begin
        errors++;
        $display("[TB] FAIL blink_digit0 frame %0d: got %0d lit cycles expected %0d", f, lit0[f],
                 (f == 2 || f == 3) ? 0 : RD - DEAD);
      end
      checks++;
      if (lit1[f] != RD - DEAD) begin
        errors++;
        $display("[TB] FAIL blink_digit1 frame %0d: got %0d lit cycles expected %0d", f, lit1[f], RD - DEAD);
      end
    end
    blink_mask = 4'b0000;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_scan();
    test_blanking();
    test_random();
    test_mid_reset();
    test_dead_zero();
`ifdef DIGIT_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
- Time-multiplexes four 5-bit character codes onto one shared 7-segment character decoder and drives the four active-low digit anodes.
- Sits directly upstream of the binary-to-segment decoder: `code` feeds the decoder's 5-bit input; `an` drives the board anodes.
- Provides per-slot dead time (anti-ghosting), per-digit blanking and a frame tick for the lock UI logic.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot; legal range >= 2.
- DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV; 0 disables dead time.
- BLINK_FRAMES, 128, full 4-digit frames per blink half-period; only used with DIGIT_BLINK_EN; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- dig0  input  5  character code for digit 0 (rightmost, an[0])
- dig1  input  5  character code for digit 1
- dig2  input  5  character code for digit 2
- dig3  input  5  character code for digit 3 (leftmost, an[3])
- blank_mask  input  4  bit i=1 forces digit i dark
- code  output  5  selected character code, to the segment decoder
- an  output  4  anode enables, active-low, at most one bit low
- digit_idx  output  2  index of the digit currently represented on code/an
- frame_tick  output  1  one-cycle pulse when the slot index wraps 3->0

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Internal state: slot counter cnt (0..REFRESH_DIV-1) and slot index idx (0..3).
  - Each cycle: if cnt==REFRESH_DIV-1 then cnt<=0 and idx<=idx+1 (mod 4, 3->0 wraps); else cnt<=cnt+1.
- Phase per slot:
  - DARK when cnt<DEAD_CYCLES, or blank_mask[idx]=1.
  - LIT otherwise.
- All outputs are registered and reflect the (idx, cnt, inputs) values of the previous cycle, i.e. exactly 1 clock of latency.
  - LIT: an = ~(4'b0001<<idx); code = dig[idx].
  - DARK: an = 4'b1111; code = 5'b10110 (space).
  - digit_idx = idx in both phases.
- frame_tick = 1 for exactly one cycle: the output cycle corresponding to counter state idx=3, cnt=REFRESH_DIV-1.
- Reset values, and values on the first cycle after reset deassertion:
  - cnt=0, idx=0
  - an=4'b1111, code=5'b10110, digit_idx=0, frame_tick=0
- Reset asserted mid-slot: on the next edge, all state and outputs return to reset values; no partial slot completes.
- Input changes:
  - dig*/blank_mask are sampled every cycle, with no capture at slot boundaries.
  - A change to the active digit appears on code 1 cycle later.
  - blank_mask asserted mid-slot darkens an on the next cycle.
- Never more than one an bit low. The transition between two lit digits always passes through at least one all-high cycle when DEAD_CYCLES>=1.
- Counter widths are sized by $clog2 of the respective parameter; no overflow is possible.

Optional Feature:
- Macro: DIGIT_BLINK_EN.
- When defined:
  - Adds input port blink_mask[3:0].
  - A blink counter increments on each frame_tick, toggling blink_phase every BLINK_FRAMES frames; blink counter and phase reset to 0 (phase 0 = visible).
  - While blink_phase=1, digits with blink_mask[i]=1 are treated as DARK for whole slots.
- When undefined:
  - No blink_mask port and no blink logic.
  - Behaviour is identical to the defined case with blink_mask=0.

Test Plan:
- Reset/startup (REFRESH_DIV=8, DEAD_CYCLES=2, dig0=5'h01): hold reset 3 cycles, release -> an=1111, code=10110 for cycles 0-2 after release; an=1110, code=00001 for cycles 3-8; an=1111 at cycle 9.
- Full scan (dig0..3 = 1,2,3,4, REFRESH_DIV=8, DEAD=2) -> an sequence 1110,1101,1011,0111 with codes 1,2,3,4 each lit 6 cycles; frame_tick high once per 32 cycles, in the cycle before digit 0 restarts; one-hot-low check on an every cycle.
- Blanking: blank_mask=4'b0100 -> an never equals 1011 and digit 2's slot is all 1111/10110; set blank_mask[0] mid-slot 0 -> an=1111 the next cycle.
- Mid-operation reset: assert reset during idx=2, cnt=5 -> next cycle an=1111, digit_idx=0, code=10110, and the scan restarts from digit 0.
- DEAD_CYCLES=0: dig0 lit from cycle 1 after release; adjacent slots switch directly, e.g. 1110 -> 1101 with no gap.
- DIGIT_BLINK_EN with BLINK_FRAMES=2, blink_mask=4'b0001 -> digit 0 lit in frames 0-1, dark in frames 2-3, lit in frames 4-5; other digits unaffected.
